// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI-Lite master bridging a local command/response port
module axi_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    A_CLK,
    input  logic                    A_RESET_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   AW_ADDR,
    output logic                    AW_VALID,
    input  logic                    AW_READY,
    output logic [DATA_WIDTH-1:0]   W_DATA,
    output logic [DATA_WIDTH/8-1:0] W_STRB,
    output logic                    W_VALID,
    input  logic                    W_READY,
    input  logic [1:0]              B_RESP,
    input  logic                    B_VALID,
    output logic                    B_READY,
    output logic [ADDR_WIDTH-1:0]   AR_ADDR,
    output logic                    AR_VALID,
    input  logic                    AR_READY,
    input  logic [DATA_WIDTH-1:0]   R_DATA,
    input  logic [1:0]              R_RESP,
    input  logic                    R_VALID,
    output logic                    R_READY
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    write_q, write_d;
    logic                    aw_valid_q, aw_valid_d;
    logic                    w_valid_q, w_valid_d;
    logic                    ar_valid_q, ar_valid_d;
    logic                    b_ready_q, b_ready_d;
    logic                    r_ready_q, r_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        ar_valid_d  = ar_valid_q;
        b_ready_d   = b_ready_q;
        r_ready_d   = r_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    write_d     = cmd_write;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = RESP_OKAY;
                    // Misaligned commands are answered locally without touching the bus
                    if (cmd_addr[1:0] != 2'b00) begin
                        rsp_resp_d  = RESP_SLVERR;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else if (cmd_write) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = WR_REQ;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (AW_READY) aw_valid_d = 1'b0;
                if (W_READY)  w_valid_d  = 1'b0;
                if (!aw_valid_d && !w_valid_d) begin
                    b_ready_d = 1'b1;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (B_VALID) begin
                    b_ready_d   = 1'b0;
                    rsp_resp_d  = B_RESP;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RD_REQ: begin
                if (AR_READY) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = RD_DATA;
                end
            end
            RD_DATA: begin
                if (R_VALID) begin
                    r_ready_d   = 1'b0;
                    rsp_rdata_d = write_q ? '0 : R_DATA;
                    rsp_resp_d  = R_RESP;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge A_CLK or negedge A_RESET_n) begin
        if (!A_RESET_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            b_ready_q   <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            ar_valid_q  <= ar_valid_d;
            b_ready_q   <= b_ready_d;
            r_ready_q   <= r_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign AW_ADDR   = addr_q;
    assign AW_VALID  = aw_valid_q;
    assign W_DATA    = wdata_q;
    assign W_STRB    = wstrb_q;
    assign W_VALID   = w_valid_q;
    assign B_READY   = b_ready_q;
    assign AR_ADDR   = addr_q;
    assign AR_VALID  = ar_valid_q;
    assign R_READY   = r_ready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - directed scoreboard bench for axi_lite_master
module tb_axi_lite_master;
    logic        A_CLK;
    logic        A_RESET_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] AW_ADDR;
    logic        AW_VALID;
    logic        AW_READY;
    logic [31:0] W_DATA;
    logic [3:0]  W_STRB;
    logic        W_VALID;
    logic        W_READY;
    logic [1:0]  B_RESP;
    logic        B_VALID;
    logic        B_READY;
    logic [31:0] AR_ADDR;
    logic        AR_VALID;
    logic        AR_READY;
    logic [31:0] R_DATA;
    logic [1:0]  R_RESP;
    logic        R_VALID;
    logic        R_READY;

    int errors = 0;
    int checks = 0;
    logic [33:0] exp_q[$];

    axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .A_CLK(A_CLK), .A_RESET_n(A_RESET_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
        .AR_ADDR(AR_ADDR), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
        .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY)
    );

    initial A_CLK = 1'b0;
    always #5 A_CLK = ~A_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge A_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, rsp_valid, rsp_resp}, 64'h0);
        check({tag, " data"}, {rsp_rdata, W_DATA}, 64'h0);
        check({tag, " addr"}, {AW_ADDR, AR_ADDR}, 64'h0);
        check({tag, " strb"}, W_STRB, 64'h0);
    endtask

    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
    endtask

    task automatic consume(input string tag, input int budget);
        logic [33:0] exp;
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                if (exp_q.size() != 0) exp = exp_q.pop_front();
                else exp = 'x;
                check({tag, " rsp"}, {rsp_rdata, rsp_resp}, exp);
                rsp_ready = 1'b1;
                tick();
                rsp_ready = 1'b0;
            end else begin
                tick();
            end
        end
        check({tag, " rsp_seen"}, got, 1);
    endtask

    initial begin
        int aw_cnt;
        int b_cnt;
        A_RESET_n = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;
        AW_READY = 0; W_READY = 0; B_RESP = 0; B_VALID = 0;
        AR_READY = 0; R_DATA = 0; R_RESP = 0; R_VALID = 0;
        tick();
        tick();
        check_all_zero("reset");
        A_RESET_n = 1'b1;
        tick();
        check("reset cmd_ready", cmd_ready, 1);

        // Aligned write, slave always ready
        AW_READY = 1; W_READY = 1; B_VALID = 1; B_RESP = 2'b00;
        send(1, 32'h04, 32'hDEADBEEF, 4'hF);
        exp_q.push_back({32'h0, 2'b00});
        tick();
        cmd_valid = 0;
        check("wr1 c1 valids", {AW_VALID, W_VALID, cmd_ready}, 3'b110);
        check("wr1 c1 addr", AW_ADDR, 32'h04);
        check("wr1 c1 data", {W_DATA, W_STRB}, {32'hDEADBEEF, 4'hF});
        tick();
        check("wr1 c2", {AW_VALID, W_VALID, B_READY, rsp_valid}, 4'b0010);
        tick();
        check("wr1 c3", {B_READY, rsp_valid}, 2'b01);
        B_VALID = 0;
        consume("wr1", 4);
        check("wr1 idle", {cmd_ready, rsp_valid}, 2'b10);

        // Write with AW_READY delayed, early B_VALID in WR_REQ
        AW_READY = 0; W_READY = 1;
        send(1, 32'h10, 32'hCAFE0001, 4'h3);
        exp_q.push_back({32'h0, 2'b00});
        tick();
        cmd_valid = 0;
        aw_cnt = 0;
        for (int c = 1; c <= 4; c++) begin
            if (AW_VALID) aw_cnt++;
            if (c == 1) check("wr2 w_valid c1", W_VALID, 1);
            if (c == 2) check("wr2 w_valid c2", W_VALID, 0);
            check("wr2 b_ready in WR_REQ", B_READY, 0);
            B_VALID  = (c == 2 || c == 3);
            B_RESP   = 2'b10;
            AW_READY = (c == 4);
            tick();
        end
        AW_READY = 0;
        check("wr2 aw_cycles", aw_cnt, 4);
        check("wr2 wr_resp", {AW_VALID, W_VALID, B_READY, rsp_valid}, 4'b0010);
        B_VALID = 1; B_RESP = 2'b00;
        b_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (B_VALID && B_READY) b_cnt++;
            tick();
        end
        B_VALID = 0;
        check("wr2 b_handshakes", b_cnt, 1);
        for (int c = 0; c < 5; c++) begin
            check("wr2 hold", {rsp_valid, cmd_ready, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b00, 32'h0});
            tick();
        end
        consume("wr2", 4);

        // Read with delayed R_VALID, SLVERR response
        AR_READY = 1; R_VALID = 0;
        send(0, 32'h0C, 32'h0, 4'h0);
        exp_q.push_back({32'h12345678, 2'b10});
        tick();
        cmd_valid = 0;
        check("rd1 c1", {AR_VALID, AW_VALID, W_VALID, R_READY}, 4'b1000);
        check("rd1 c1 addr", AR_ADDR, 32'h0C);
        tick();
        check("rd1 c2", {AR_VALID, R_READY}, 2'b01);
        tick();
        check("rd1 c3", {R_READY, rsp_valid}, 2'b10);
        R_VALID = 1; R_DATA = 32'h12345678; R_RESP = 2'b10;
        tick();
        R_VALID = 0; R_DATA = 0; R_RESP = 0;
        check("rd1 c4", {R_READY, rsp_valid}, 2'b01);
        consume("rd1", 4);

        // Misaligned write and read: local SLVERR, no bus traffic
        AR_READY = 0;
        send(1, 32'h06, 32'h11112222, 4'hF);
        exp_q.push_back({32'h0, 2'b10});
        tick();
        cmd_valid = 0;
        check("mis1 c1", {rsp_valid, AW_VALID, W_VALID, AR_VALID}, 4'b1000);
        consume("mis1", 2);
        check("mis1 after", {AW_VALID, W_VALID, AR_VALID, cmd_ready}, 4'b0001);
        send(0, 32'h0D, 32'h0, 4'h0);
        exp_q.push_back({32'h0, 2'b10});
        tick();
        cmd_valid = 0;
        check("mis2 c1", {rsp_valid, AW_VALID, W_VALID, AR_VALID}, 4'b1000);
        consume("mis2", 2);

        // Reset during WR_RESP abandons the write
        AW_READY = 1; W_READY = 1; B_VALID = 0;
        send(1, 32'h20, 32'h55AA55AA, 4'hF);
        tick();
        cmd_valid = 0;
        tick();
        check("rst wr_resp", B_READY, 1);
        #2 A_RESET_n = 1'b0;
        #1;
        check_all_zero("rst async");
        tick();
        tick();
        A_RESET_n = 1'b1;
        AW_READY = 0; W_READY = 0;
        tick();
        check("rst released", {cmd_ready, rsp_valid}, 2'b10);

        // Fresh read after reset, all-ready slave
        AR_READY = 1; R_VALID = 1; R_DATA = 32'hA5A50F0F; R_RESP = 2'b00;
        send(0, 32'h40, 32'h0, 4'h0);
        exp_q.push_back({32'hA5A50F0F, 2'b00});
        tick();
        cmd_valid = 0;
        check("rd2 c1", {AR_VALID, rsp_valid}, 2'b10);
        tick();
        check("rd2 c2", {R_READY, rsp_valid}, 2'b10);
        tick();
        check("rd2 c3", {R_READY, rsp_valid}, 2'b01);
        consume("rd2", 4);
        R_VALID = 0;

        check("scoreboard empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 ADDR_WIDTH, 32, address width of the cmd_addr port and the AW/AR channels.
REQ-002 DATA_WIDTH, 32, data width of the command/response ports and the W/R channels; strobe width is DATA_WIDTH/8.
REQ-003 A_CLK  input  1  single clock; all logic is rising-edge.
REQ-004 A_RESET_n  input  1  reset, asynchronous and active-low.
REQ-005 cmd_valid  input  1  local command request.
REQ-006 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  ADDR_WIDTH  byte address.
REQ-009 cmd_wdata  input  DATA_WIDTH  write data.
REQ-010 cmd_wstrb  input  DATA_WIDTH/8  write byte strobes.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-013 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
REQ-014 rsp_resp  output  2  response code: 2'b00 OKAY, 2'b10 SLVERR.
REQ-015 AW_ADDR / AW_VALID  output  ADDR_WIDTH / 1  write address channel; AW_READY  input  1.
REQ-016 W_DATA / W_STRB / W_VALID  output  DATA_WIDTH / DATA_WIDTH/8 / 1  write data channel; W_READY  input  1.
REQ-017 B_RESP  input  2, B_VALID  input  1, B_READY  output  1  write response channel.
REQ-018 AR_ADDR / AR_VALID  output  ADDR_WIDTH / 1  read address channel; AR_READY  input  1.
REQ-019 R_DATA  input  DATA_WIDTH, R_RESP  input  2, R_VALID  input  1, R_READY  output  1  read data channel.

Function
REQ-020 The block SHALL use states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA and RESP, with at most one transaction outstanding.
REQ-021 cmd_ready SHALL be 1 only in IDLE; on a cmd handshake, the block SHALL register cmd_addr, cmd_wdata, cmd_wstrb and cmd_write.
REQ-022 If a command is accepted with cmd_addr[1:0] != 0, the block SHALL issue no bus traffic and SHALL enter RESP with rsp_resp=2'b10 and rsp_rdata=0.
REQ-023 For an aligned write, the block SHALL enter WR_REQ and assert AW_VALID and W_VALID together in the cycle after acceptance.
REQ-024 In WR_REQ, each of AW_VALID and W_VALID SHALL drop independently on its own handshake.
REQ-025 Once both the AW and W handshakes have completed, in either order or in the same cycle, the block SHALL go to WR_RESP.
REQ-026 In WR_RESP, B_READY SHALL be 1; on a B handshake the block SHALL capture B_RESP into rsp_resp and go to RESP.
REQ-027 For an aligned read, the block SHALL enter RD_REQ with AR_VALID=1 until AR_READY is seen, then go to RD_DATA.
REQ-028 In RD_DATA, R_READY SHALL be 1; on an R handshake the block SHALL capture R_DATA and R_RESP and go to RESP.
REQ-029 In RESP, rsp_valid SHALL be 1 and all outputs SHALL be stable until rsp_ready; the block SHALL then return to IDLE, and a new command SHALL be accepted no earlier than the next cycle.
REQ-030 Once a VALID is asserted, it SHALL NOT be deasserted before its handshake; ADDR, DATA and STRB SHALL remain stable while VALID is high.
REQ-031 B_READY SHALL be 0 outside WR_RESP and R_READY SHALL be 0 outside RD_DATA; B_VALID and R_VALID arriving in any other state SHALL be ignored.
REQ-032 All bus and response outputs SHALL be driven directly from registers, with no combinational path from any input.
REQ-033 Minimum latency, for slave ready signals held high: write 3 cycles from command accept to rsp_valid; read 3 cycles.

Reset
REQ-034 While A_RESET_n=0, the state SHALL be IDLE and all VALID/READY outputs, rsp_valid, rsp_rdata, rsp_resp and all address/data/strobe outputs SHALL be 0; cmd_ready SHALL be 1 after reset is released.
REQ-035 A reset asserted mid-transaction SHALL abandon the transaction immediately and asynchronously, with no response generated.

Verification
REQ-036 Write 0x04 data 0xDEADBEEF strb 0xF, slave always ready -> AW/W valid together for 1 cycle, B_READY, rsp_valid with rsp_resp=00 three cycles after accept.
REQ-037 Write with AW_READY delayed 3 cycles and W_READY immediate -> W_VALID drops after 1 cycle, AW_VALID held 4 cycles, exactly one B handshake.
REQ-038 Read 0x0C, slave returns R_DATA=0x12345678 and R_RESP=10 after 2-cycle R_VALID delay -> rsp_rdata=0x12345678, rsp_resp=10.
REQ-039 Command to addr 0x06 -> no AW/AR VALID ever asserted; rsp_valid next cycle with rsp_resp=10.
REQ-040 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0 throughout; an early B_VALID in WR_REQ is ignored.
REQ-041 A_RESET_n pulsed low during WR_RESP -> all outputs 0 immediately; after release, a fresh read completes normally.
